// File: rtl/lb_uart_rx.sv
// lb_uart_rx: 8N1 UART receiver with 2-flop input synchronizer and mid-bit
// sampling driven by an external oversampling baud tick (OVERSAMPLE ticks per
// bit). Received bytes are presented on dout with a 1-clk rxDone strobe.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the last
// data bit and the stop bit, plus parityOdd/parityError ports.
module lb_uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baudTick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parityOdd,
  output logic                 parityError,
`endif
  output logic [DATA_BITS-1:0] dout,
  output logic                 rxDone,
  output logic                 framingError,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic                 rxS1_q;
  logic                 rxS2_q;
  logic                 rxPrev_q;
  state_t               state_q;
  logic [TW-1:0]        tickCnt_q;
  logic [BW-1:0]        bitCnt_q;
  logic [DATA_BITS-1:0] shiftReg_q;
  logic [DATA_BITS-1:0] shiftReg_d;
  logic [DATA_BITS-1:0] dout_q;
  logic                 rxDone_q;
  logic                 framingError_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 parErr_q;
  logic                 parityError_q;
`endif

  // LSB-first shift: the newest sample enters at the MSB end.
  assign shiftReg_d = {rxS2_q, shiftReg_q[DATA_BITS-1:1]};

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxS1_q   <= 1'b1;
      rxS2_q   <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxS1_q   <= rx;
      rxS2_q   <= rxS1_q;
      rxPrev_q <= rxS2_q;
    end
  end

  // Receive FSM: start-edge detect, mid-bit sampling, registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      tickCnt_q      <= '0;
      bitCnt_q       <= '0;
      shiftReg_q     <= '0;
      dout_q         <= '0;
      rxDone_q       <= 1'b0;
      framingError_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_q       <= 1'b0;
      parityError_q  <= 1'b0;
`endif
    end else begin
      rxDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tickCnt_q <= '0;
          // Only a 1->0 transition starts a frame; a line stuck low does not.
          if (rxPrev_q && !rxS2_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (baudTick) begin
            if (tickCnt_q == TICK_MID) begin
              tickCnt_q <= '0;
              if (!rxS2_q) begin
                state_q  <= DATA;
                bitCnt_q <= '0;
              end else begin
                // Start bit no longer low at its centre: treat as a glitch.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tickCnt_q <= tickCnt_q + TICK_ONE;
            end
          end
        end

        DATA: begin
          if (baudTick) begin
            if (tickCnt_q == TICK_END) begin
              tickCnt_q  <= '0;
              shiftReg_q <= shiftReg_d;
              if (bitCnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bitCnt_q <= bitCnt_q + BIT_ONE;
              end
            end else begin
              tickCnt_q <= tickCnt_q + TICK_ONE;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baudTick) begin
            if (tickCnt_q == TICK_END) begin
              tickCnt_q <= '0;
              parErr_q  <= (^shiftReg_q) ^ rxS2_q ^ parityOdd;
              state_q   <= STOP;
            end else begin
              tickCnt_q <= tickCnt_q + TICK_ONE;
            end
          end
        end
`endif

        STOP: begin
          if (baudTick) begin
            if (tickCnt_q == TICK_END) begin
              tickCnt_q      <= '0;
              rxDone_q       <= 1'b1;
              framingError_q <= ~rxS2_q;
              state_q        <= IDLE;
              busy_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
              parityError_q  <= parErr_q;
              if (rxS2_q && !parErr_q) dout_q <= shiftReg_q;
`else
              if (rxS2_q) dout_q <= shiftReg_q;
`endif
            end else begin
              tickCnt_q <= tickCnt_q + TICK_ONE;
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          tickCnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dout         = dout_q;
  assign rxDone       = rxDone_q;
  assign framingError = framingError_q;
  assign busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parityError  = parityError_q;
`endif

endmodule

// File: tb/tb_lb_uart_rx.sv
// Testbench for lb_uart_rx: table of frames driven on rx with a scoreboard
// queue of expected results checked on every rxDone, plus hand-written
// sequences for break, glitch, mid-frame reset and (optionally) parity.
`timescale 1ns/1ps
module tb_lb_uart_rx;
  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TCLK     = 4;
  localparam int BIT_CLKS = OS * TCLK;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int DONE_CLKS  = (OS / 2 + OS * (NBITS - 1)) * TCLK;
  localparam int FRAME_CLKS = OS * NBITS * TCLK;

  logic          clk;
  logic          reset;
  logic          baudTick;
  logic          rx;
  logic          parityOdd;
  logic [DW-1:0] dout;
  logic          rxDone;
  logic          framingError;
  logic          busy;
  logic          parityError;

  lb_uart_rx #(.DATA_BITS(DW), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .baudTick     (baudTick),
    .rx           (rx),
`ifdef UART_RX_PARITY_EN
    .parityOdd    (parityOdd),
    .parityError  (parityError),
`endif
    .dout         (dout),
    .rxDone       (rxDone),
    .framingError (framingError),
    .busy         (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parityError = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    int         gap;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_push = 0;
  int   last_fall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // baudTick: one clk high out of every TCLK
  initial begin
    int tdiv;
    tdiv = 0;
    baudTick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % TCLK;
      baudTick = (tdiv == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, LSB first; must be called at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb);
    logic [10:0] fr;
    fr = (NBITS == 11) ? {stopb, parb, d, 1'b0} : {1'b1, stopb, d, 1'b0};
    for (int i = 0; i < NBITS; i++) begin
      rx = fr[i];
      if (i == 0) last_fall = cyc;
      wait_clks(BIT_CLKS);
      if (i == 0) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    end
  endtask

  // Scoreboard: every rxDone pops one expected record
  initial begin
    forever begin
      @(negedge clk);
      if (rxDone === 1'b1) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rxDone: got dout=%0h fe=%0b expected no strobe", dout, framingError);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_dout", {24'd0, dout}, {24'd0, e.d});
          chk("rx_framingError", {31'd0, framingError}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
          chk("rx_parityError", {31'd0, parityError}, {31'd0, e.pe});
`endif
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   fall0;
    int   bcnt;
    logic par;

    vecs[0] = '{8'h55, 1'b1, 16, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 16, 8'hA3, 1'b0};
    vecs[2] = '{8'h0F, 1'b1,  0, 8'h0F, 1'b0};
    vecs[3] = '{8'hC6, 1'b1,  4, 8'hC6, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 16, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b1,  0, 8'hFF, 1'b0};
    vecs[6] = '{8'h0F, 1'b1, 16, 8'h0F, 1'b0};
    vecs[7] = '{8'h3C, 1'b0, 16, 8'h0F, 1'b1};

    reset = 1'b0;
    rx = 1'b1;
    parityOdd = 1'b0;
    fall0 = 0;
    wait_clks(5);
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_rxDone", {31'd0, rxDone}, 32'd0);
    chk("reset_framingError", {31'd0, framingError}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_parityError", {31'd0, parityError}, 32'd0);
    reset = 1'b1;
    wait_clks(BIT_CLKS);

    // Table of frames; the last entry has a bad stop bit
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      wait_clks(vecs[i].gap * TCLK);
      par = (^vecs[i].d) ^ parityOdd;
      push_exp(vecs[i].exp_d, vecs[i].exp_fe, 1'b0);
      send_frame(vecs[i].d, vecs[i].stopb, par);
      if (i == 0) fall0 = last_fall;
    end

    chk_range("start_to_done_clks", done_cyc[0] - fall0, DONE_CLKS, DONE_CLKS + TCLK - 1);
    chk("back_to_back_spacing", done_cyc[2] - done_cyc[1], FRAME_CLKS);

    // Break: line stays low after the framing error, no retrigger
    rx = 1'b0;
    wait_clks(3 * BIT_CLKS);
    chk("break_no_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, (^8'h5A) ^ parityOdd);
    wait_clks(BIT_CLKS);

    // Start-bit glitch of 3 ticks
    bcnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 11) rx = 1'b1;
      if (busy === 1'b1) bcnt++;
    end
    chk_range("glitch_busy_clks", bcnt, 26, 34);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    chk("glitch_dout_kept", {24'd0, dout}, 32'h5A);
    wait_clks(BIT_CLKS);

    // Reset pulse during bit 4 of 0xFF
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_dout", {24'd0, dout}, 32'd0);
    chk("midreset_rxDone", {31'd0, rxDone}, 32'd0);
    chk("midreset_framingError", {31'd0, framingError}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    wait_clks(6 * BIT_CLKS);
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, (^8'h81) ^ parityOdd);
    wait_clks(BIT_CLKS);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the good parity bit is 1
    parityOdd = 1'b0;
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(BIT_CLKS);
    push_exp(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    chk("parity_dout_kept", {24'd0, dout}, 32'h07);
`endif

    wait_clks(2 * BIT_CLKS);
    chk("pending_expected", exp_q.size(), 32'd0);
    chk("rxDone_count", done_cyc.size(), n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lb_uart_rx.md
Name: lb_uart_rx

Overview:
UART receiver paired with the existing UART transmit path (lb_UART_Tx_FSM). It recovers 8N1 serial frames from the rx pin using an external oversampling baud tick. A 2-flop synchronizer feeds an FSM that mid-bit samples the data and presents each received byte with a 1-cycle strobe. It sits between the pad and the PicoBlaze input port / interrupt logic.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first.
OVERSAMPLE, 16, baudTick pulses per bit period; must be even and >= 4.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-low reset; 0 = reset.
baudTick  input  1  1-clk pulse, OVERSAMPLE per bit period, from the baud generator.
rx  input  1  asynchronous serial line; idle level is 1.
dout  output  DATA_BITS  last received byte; held until the next good frame.
rxDone  output  1  1-clk pulse when dout updates or a frame fails the stop-bit check.
framingError  output  1  registered with rxDone; 1 = stop bit sampled low.
busy  output  1  1 while FSM is not IDLE.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, rxSync flops=1, tickCnt=0, bitCnt=0, shiftReg=0, dout=0, rxDone=0, framingError=0, busy=0. Reset mid-frame discards the partial byte and does not pulse rxDone.
- Synchronizer: rx -> rxS1 -> rxS2; rxPrev = rxS2 delayed 1 clk. All FSM decisions use rxS2.
- tickCnt: width clog2(OVERSAMPLE). Advances only on cycles with baudTick=1. Clears on every state change.
- IDLE: falling edge (rxPrev=1, rxS2=0) -> START, independent of baudTick. A steady low line, such as a break after a framing error, does not retrigger.
- START: on baudTick with tickCnt==OVERSAMPLE/2-1, check rxS2. If 0 -> DATA with bitCnt=0; if 1 -> IDLE (glitch rejected, no rxDone). Otherwise tickCnt++.
- DATA: on baudTick with tickCnt==OVERSAMPLE-1, shiftReg <= {rxS2, shiftReg[DATA_BITS-1:1]}. Then:
  - bitCnt==DATA_BITS-1 -> STOP (or PARITY, see Optional Feature);
  - else bitCnt++.
- STOP: on baudTick with tickCnt==OVERSAMPLE-1, sample rxS2.
  - Always: rxDone=1 for exactly one clk; framingError=~rxS2; -> IDLE.
  - dout <= shiftReg only when rxS2=1. On error, dout is unchanged.
- framingError holds its value until the next rxDone.
- Timing: all sample points fall mid-bit. rxDone asserts 2 sync clks + (OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1)) ticks (+1 clk) after the rx falling edge; 152 ticks at defaults.
- Back-to-back frames: FSM is back in IDLE at mid stop bit, so the next start edge is accepted with zero idle gap.
- baudTick held high continuously: counts every clk (legal; used for fast simulation).
- busy=1 in START/DATA/STOP(/PARITY).

Optional Feature:
UART_RX_PARITY_EN.
- Defined: adds a 1-bit input parityOdd (0 = even, 1 = odd) and an output parityError.
  - DATA -> PARITY after the last data bit.
  - PARITY samples one bit at tickCnt==OVERSAMPLE-1, then -> STOP.
  - parityError = (^shiftReg ^ sampledBit ^ parityOdd) != 0, registered with rxDone. Reset value 0.
  - dout updates only when both parity and stop bit are good.
- Undefined: no PARITY state, no parityOdd/parityError ports; frame is 8N1.

Test Plan:
1. Bench drives baudTick every 4 clks; send 0x55 with a good stop bit -> one rxDone pulse 152 ticks after the start edge, dout=0x55, framingError=0, busy falls with rxDone.
2. Frames 0xA3 then 0x0F with no idle gap -> two rxDone pulses 160 ticks apart; dout=0xA3, then 0x0F; framingError=0 both times.
3. Send 0x3C with stop bit=0 -> rxDone pulses, framingError=1, dout keeps the prior value 0x0F; line held low afterwards -> no further rxDone until rx returns high and falls again.
4. rx low glitch of 3 ticks -> FSM returns to IDLE at tick 7, no rxDone, busy=1 for about 8 ticks only.
5. reset=0 for 1 clk during bit 4 of 0xFF -> all outputs 0 on the next clk, no rxDone; the following frame 0x81 is received correctly.
6. With UART_RX_PARITY_EN defined and parityOdd=0: send 0x07 with parity bit 1 -> parityError=0, dout=0x07. Send 0x07 with parity bit 0 -> parityError=1, dout unchanged.
